// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the PageRank front end: FSM states,
// default sizing and the row popcount used to derive out-degree.
package pagerank_pkg;

    localparam int PR_N     = 16;
    localparam int PR_WIDTH = 16;
    localparam int DEG_W    = $clog2(PR_N + 1);
    localparam int IDX_W    = $clog2(PR_N);

    typedef enum logic [2:0] {
        IDLE,
        DEG,
        DIV,
        WRITE,
        FIN
    } state_t;

    // Row is zero-extended to 64 bits by the caller so one helper serves every N.
    function automatic logic [6:0] popcount(input logic [63:0] row);
        logic [6:0] c;
        c = '0;
        for (int k = 0; k < 64; k++) begin
            c = c + 7'(row[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/recip_div.sv
// Serial restoring divider computing 2^WIDTH / divisor, one quotient bit per
// cycle MSB first. WIDTH+1 iterations after load; done marks the last one.
module recip_div
    import pagerank_pkg::*;
#(
    parameter int WIDTH = PR_WIDTH,
    parameter int DW    = DEG_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [DW-1:0]   divisor,
    output logic [WIDTH:0]  quotient,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [DW-1:0] dvs;
    logic [DW:0]   rem;
    logic [CW-1:0] cnt;
    logic [DW:0]   rem_sh;
    logic [DW:0]   rem_nx;
    logic          qbit;

    // One restoring step: bring in the next dividend bit (only the MSB is 1),
    // subtract when it fits. A zero divisor yields all-ones, masked later.
    always_comb begin
        rem_sh = {rem[DW-1:0], (cnt == CW'(WIDTH))};
        qbit   = (rem_sh >= {1'b0, dvs});
        rem_nx = qbit ? (rem_sh - {1'b0, dvs}) : rem_sh;
        done   = busy && (cnt == '0);
    end

    // Iteration state: load primes the divider, then count down WIDTH..0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            quotient <= '0;
            busy     <= 1'b0;
        end else if (load) begin
            dvs      <= divisor;
            rem      <= '0;
            cnt      <= CW'(WIDTH);
            quotient <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            rem      <= rem_nx;
            quotient <= {quotient[WIDTH-1:0], qbit};
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/page_weight_gen.sv
// Out-degree reciprocal generator feeding the PageRank core. Latches the
// adjacency matrix, then walks nodes 0..N-1 through one shared divider,
// writing each node's 1/outdegree weight in Q0.WIDTH.
module page_weight_gen
    import pagerank_pkg::*;
#(
    parameter int N     = PR_N,
    parameter int WIDTH = PR_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*N-1:0]     adj,
    output logic [N*WIDTH-1:0] nodeWeight,
    output logic               busy,
    output logic               done,
    output logic               valid
);

    localparam int DW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   idx;
    logic [N*N-1:0]  adj_q;
    logic [63:0]     row;
    logic [DW-1:0]   deg;
    logic            div_load;
    logic            div_busy;
    logic            div_done;
    logic [WIDTH:0]  quot;
    logic [WIDTH-1:0] weight;

    recip_div #(
        .WIDTH (WIDTH),
        .DW    (DW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .divisor  (deg),
        .quotient (quot),
        .busy     (div_busy),
        .done     (div_done)
    );

    // Out-degree of the current row and its saturated / zero-masked weight.
    // idx and adj_q are stable from DEG through WRITE, so deg stays valid.
    always_comb begin
        row        = '0;
        row[N-1:0] = adj_q[idx*N +: N];
        deg        = DW'(popcount(row));
        if (deg == '0) begin
            weight = '0;
        end else if (quot[WIDTH]) begin
            weight = '1;
        end else begin
            weight = quot[WIDTH-1:0];
        end
    end

    // Next-state logic; the divider is loaded during the single DEG cycle.
    always_comb begin
        state_nx = state;
        div_load = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = DEG;
            DEG: begin
                div_load = 1'b1;
                state_nx = DIV;
            end
            // An idle divider without done cannot occur in normal flow;
            // treating it as finished keeps the FSM from ever stalling.
            DIV:   if (div_done || !div_busy) state_nx = WRITE;
            WRITE: state_nx = (idx == IW'(N - 1)) ? FIN : DEG;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, node index, adjacency latch, weight bus and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            adj_q      <= '0;
            nodeWeight <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        adj_q <= adj;
                        idx   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                WRITE: begin
                    nodeWeight[idx*WIDTH +: WIDTH] <= weight;
                    if (idx != IW'(N - 1)) begin
                        idx <= idx + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_page_weight_gen.sv
// Directed bench for page_weight_gen with hand-computed weights.
module tb_page_weight_gen;

    localparam int N     = 16;
    localparam int WIDTH = 16;
    localparam int LAT   = N * (WIDTH + 3) + 1;

    logic               clk;
    logic               reset;
    logic               start;
    logic [N*N-1:0]     adj;
    logic [N*WIDTH-1:0] nodeWeight;
    logic               busy;
    logic               done;
    logic               valid;

    int errors;
    int checks;

    logic [N*N-1:0]   mat_a;
    logic [N*N-1:0]   mat_deg;
    logic [N*N-1:0]   mat_sat;
    logic [WIDTH-1:0] exp_a   [N];
    logic [WIDTH-1:0] exp_deg [N];

    page_weight_gen #(.N(N), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .adj        (adj),
        .nodeWeight (nodeWeight),
        .busy       (busy),
        .done       (done),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start from IDLE; returns 1 ns after the accept edge.
    task automatic do_start(input logic [N*N-1:0] a);
        @(negedge clk);
        adj   = a;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges counted from the caller's reference edge until done is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        adj   = '0;
        #2 reset = 1'b1;
        #5;
        checks++;
        if (nodeWeight !== '0 || busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: nw=%h busy=%b done=%b valid=%b, required all zero",
                     nodeWeight, busy, done, valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_bench_matrix;
        int cyc;
        do_start(mat_a);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_flags: busy=%b valid=%b, required busy=1 valid=0", busy, valid);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL bench_latency: got %0d cycles, required %0d", cyc, LAT);
        end
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bench_done_flags: valid=%b busy=%b, required valid=1 busy=0", valid, busy);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (nodeWeight[i*WIDTH +: WIDTH] !== exp_a[i]) begin
                errors++;
                $display("FAIL bench_node%0d: got %h, required %h", i, nodeWeight[i*WIDTH +: WIDTH], exp_a[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_degrees;
        int cyc;
        do_start(mat_deg);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL deg_latency: got %0d cycles, required %0d", cyc, LAT);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (nodeWeight[i*WIDTH +: WIDTH] !== exp_deg[i]) begin
                errors++;
                $display("FAIL deg_node%0d: got %h, required %h", i, nodeWeight[i*WIDTH +: WIDTH], exp_deg[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int pulses;
        do_start(mat_a);
        repeat (49) @(posedge clk);
        @(negedge clk);
        adj   = mat_deg;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc < 0 || cyc + 50 !== LAT) begin
            errors++;
            $display("FAIL ignored_start_latency: got %0d cycles, required %0d", (cyc < 0) ? cyc : cyc + 50, LAT);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (nodeWeight[i*WIDTH +: WIDTH] !== exp_a[i]) begin
                errors++;
                $display("FAIL ignored_start_node%0d: got %h, required %h", i, nodeWeight[i*WIDTH +: WIDTH], exp_a[i]);
            end
        end
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL ignored_start_extra_done: got %0d extra pulses, required 0", pulses);
        end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        int pulses;
        do_start(mat_a);
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || nodeWeight[2*WIDTH +: WIDTH] !== 16'h8000) begin
            errors++;
            $display("FAIL midrun_progress: busy=%b node2=%h, required busy=1 node2=8000",
                     busy, nodeWeight[2*WIDTH +: WIDTH]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (nodeWeight !== '0 || busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: nw=%h busy=%b valid=%b done=%b, required all zero",
                     nodeWeight, busy, valid, done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d done pulses, required 0", pulses);
        end
        do_start(mat_deg);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d cycles, required %0d", cyc, LAT);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (nodeWeight[i*WIDTH +: WIDTH] !== exp_deg[i]) begin
                errors++;
                $display("FAIL post_reset_node%0d: got %h, required %h", i, nodeWeight[i*WIDTH +: WIDTH], exp_deg[i]);
            end
        end
    endtask

    task automatic test_zero_rerun;
        int cyc;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_pre_valid: valid=%b, required 1", valid);
        end
        do_start('0);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_valid_fall: valid=%b after accept, required 0", valid);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: cycles=%0d valid=%b, required %0d and 1", cyc, valid, LAT);
        end
        checks++;
        if (nodeWeight !== '0) begin
            errors++;
            $display("FAIL zero_weights: got %h, required 0", nodeWeight);
        end
    endtask

    task automatic test_saturation;
        int cyc;
        do_start(mat_sat);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL sat_latency: got %0d cycles, required %0d", cyc, LAT);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (nodeWeight[i*WIDTH +: WIDTH] !== ((i == 3) ? 16'hFFFF : 16'h0000)) begin
                errors++;
                $display("FAIL sat_node%0d: got %h, required %h", i, nodeWeight[i*WIDTH +: WIDTH],
                         (i == 3) ? 16'hFFFF : 16'h0000);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        mat_a = '0;
        mat_a[45]  = 1'b1; mat_a[46]  = 1'b1; mat_a[75]  = 1'b1; mat_a[81]  = 1'b1;
        mat_a[96]  = 1'b1; mat_a[113] = 1'b1; mat_a[129] = 1'b1; mat_a[131] = 1'b1;
        mat_a[132] = 1'b1; mat_a[137] = 1'b1; mat_a[138] = 1'b1; mat_a[140] = 1'b1;
        mat_a[230] = 1'b1; mat_a[245] = 1'b1;
        for (int i = 0; i < N; i++) exp_a[i] = 16'h0000;
        exp_a[2]  = 16'h8000;
        exp_a[4]  = 16'hFFFF; exp_a[5]  = 16'hFFFF; exp_a[6] = 16'hFFFF; exp_a[7] = 16'hFFFF;
        exp_a[14] = 16'hFFFF; exp_a[15] = 16'hFFFF;
        exp_a[8]  = 16'h2AAA;

        mat_deg = '0;
        for (int j = 0; j < N; j++) mat_deg[j] = 1'b1;
        mat_deg[16 + 1] = 1'b1; mat_deg[16 + 7] = 1'b1; mat_deg[16 + 12] = 1'b1;
        for (int i = 0; i < N; i++) exp_deg[i] = 16'h0000;
        exp_deg[0] = 16'h1000;
        exp_deg[1] = 16'h5555;

        mat_sat = '0;
        mat_sat[3*N + 9] = 1'b1;

        test_reset;
        test_bench_matrix;
        test_degrees;
        test_back_to_back;
        test_reset_midrun;
        test_zero_rerun;
        test_saturation;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/page_weight_gen.md
Name: page_weight_gen

Overview:
Upstream feeder for the PageRank core.
- Latches the flat N×N adjacency matrix and computes each node's out-degree.
- Produces the per-node outbound weight 1/outdegree in unsigned Q0.WIDTH fixed point, packed into the nodeWeight bus the PageRank core consumes.
- Uses one shared serial restoring divider, iterating nodes 0..N-1 with deterministic latency.

Parameters:
- N, 16, number of nodes (power of two, 2..64).
- WIDTH, 16, weight width in bits (unsigned Q0.WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- adj  input  N*N  adjacency; adj[i*N+j]=1 means node i links to node j; captured on accepted start.
- nodeWeight  output  N*WIDTH  node i weight at [i*WIDTH +: WIDTH]; registered.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when all N weights are written.
- valid  output  1  nodeWeight complete and stable; cleared on accepted start, set with done.

Behaviour:
- Reset state (asynchronous, any state): FSM=IDLE, nodeWeight=0, busy=0, done=0, valid=0, node index=0, latched adj=0.
- A reset mid-operation aborts the run; no partial result is kept.
- Weight rule:
  - deg = popcount(adj_latched[i*N +: N]), held in clog2(N+1) bits.
  - weight = min(floor(2^WIDTH / deg), 2^WIDTH − 1).
  - deg=1 gives all-ones (saturated).
  - deg=0 (dangling node) gives 0.
- FSM states: IDLE, DEG, DIV, WRITE, FIN.
  - IDLE: on start=1, latch adj, idx←0, valid←0, busy←1, go to DEG. Otherwise hold; outputs unchanged.
  - DEG (1 cycle): compute popcount of row idx into the divisor register; load dividend 2^WIDTH; go to DIV.
  - DIV (exactly WIDTH+1 cycles):
    - restoring divide producing a WIDTH+1-bit quotient, one bit per cycle, MSB first;
    - the iteration counter counts down from WIDTH to 0;
    - deg=0 still spends the WIDTH+1 cycles, so latency is fixed.
  - WRITE (1 cycle):
    - apply saturation and the zero-degree rule;
    - write the result to nodeWeight[idx*WIDTH +: WIDTH]; all other slices hold;
    - if idx==N−1 go to FIN, else idx←idx+1 and go to DEG.
  - FIN (1 cycle): done←1, valid←1, busy←0; return to IDLE.
- Timing:
  - per node: WIDTH+3 cycles;
  - start-accept edge to done-high edge: N*(WIDTH+3)+1 cycles (305 for the defaults);
  - done is high for exactly one cycle.
- start while busy (DEG/DIV/WRITE/FIN) is ignored. The adj latch is not updated, and the in-flight result depends only on the latched adj.
- start asserted in the same cycle as the FIN→IDLE transition is ignored; it must be reissued while in IDLE.
- Changes on the adj input after acceptance have no effect.
- nodeWeight slices for nodes not yet processed keep their previous-run values while valid=0. Consumers must gate on valid.
- Remainder is discarded; no rounding.

Decomposition:
- Shared package pagerank_pkg:
  - FSM state enum (IDLE, DEG, DIV, WRITE, FIN);
  - localparams DEG_W = clog2(N+1) and IDX_W = clog2(N);
  - a popcount function over an N-bit row.
- One sub-module: recip_div.
  - Serial restoring divider, parameter WIDTH.
  - Ports: clk, reset, load, divisor[DEG_W], quotient[WIDTH+1], busy, done.
  - The FSM's DIV state waits on its done.

Test Plan:
- Reset, then start with the PageRank bench matrix (N=16, WIDTH=16; bits 45, 46, 75, 81, 96, 113, 129, 131, 132, 137, 138, 140, 230, 245 set) -> done at 305 cycles. Expected weights: node2=0x8000, node4=0xFFFF, node5/6/7/14/15=0xFFFF, node8=0x2AAA, nodes 0, 1, 3, 9–13 = 0x0000; valid=1.
- Row 0 all ones (deg=16) and row 1 with 3 bits set -> node0=0x1000, node1=0x5555; all other nodes 0x0000.
- Assert start again at cycle 50 of a run, with a different adj driven -> ignored. Result matches the first adj; done pulses once, at cycle 305.
- Assert reset at cycle 100 of a run -> nodeWeight=0, busy=0, valid=0 immediately, with no done pulse. A new start then completes normally with correct weights.
- Complete a run, then a second start with adj all zeros -> valid falls the cycle after acceptance; final nodeWeight all 0x0000; valid=1 with done.
- Row 3 with exactly 1 bit set -> node3=0xFFFF (saturation, not 0x0000 from 17-bit truncation).
